bus_master_port: RTL

- Serial bus master interface that sits directly downstream of the application blocks, such as the increment/display block.
- Application side: accepts a parallel transaction request (slave select, memory address, data, read/write).
- Bus side: requests the arbiter, serialises the transaction onto the one-bit bus, and returns completion (m_tx_done) plus read data.
- Bridges the application's parallel handshake to the arbitrated serial bus.

---
 rtl/bus_master_port.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/bus_master_port.sv
// Serial bus master port: latches a parallel request, wins the arbiter, and shifts
// the transaction LSB-first onto a one-bit bus. Optional macro: MASTER_TIMEOUT_EN.

module bus_master_port #(
    parameter int SLAVE_SEL_WIDTH = 2,
    parameter int ADDR_WIDTH      = 12,
    parameter int DATA_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       m_execute,
    input  logic                       m_write,
    input  logic [SLAVE_SEL_WIDTH-1:0] m_slave_sel,
    input  logic [ADDR_WIDTH-1:0]      m_addr,
    input  logic [DATA_WIDTH-1:0]      m_data_in,
    output logic [DATA_WIDTH-1:0]      m_data_out,
    output logic                       m_tx_done,
    output logic                       m_error,
    output logic                       m_busy,
    output logic                       mreq,
    input  logic                       mgrant,
    output logic                       mout,
    output logic                       mvalid,
    output logic                       mmode,
    input  logic                       sready,
    input  logic                       svalid,
    input  logic                       sin
);

    localparam int SA_MAX = (SLAVE_SEL_WIDTH > ADDR_WIDTH) ? SLAVE_SEL_WIDTH : ADDR_WIDTH;
    localparam int MAXW   = (SA_MAX > DATA_WIDTH) ? SA_MAX : DATA_WIDTH;
    localparam int CNT_W  = $clog2(MAXW + 1);

    localparam logic [CNT_W-1:0] SEL_LAST  = CNT_W'(SLAVE_SEL_WIDTH - 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_REQ      = 4'd1;
    localparam logic [3:0] S_SADDR    = 4'd2;
    localparam logic [3:0] S_WAIT_RDY = 4'd3;
    localparam logic [3:0] S_ADDR     = 4'd4;
    localparam logic [3:0] S_WDATA    = 4'd5;
    localparam logic [3:0] S_RWAIT    = 4'd6;
    localparam logic [3:0] S_RDATA    = 4'd7;
    localparam logic [3:0] S_DONE     = 4'd8;

    logic [3:0]                 state_q, state_d;
    logic [CNT_W-1:0]           bitCnt_q, bitCnt_d;
    logic                       write_q, write_d;
    logic [SLAVE_SEL_WIDTH-1:0] sel_q, sel_d;
    logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
    logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
    logic [MAXW-1:0]            txShift_q, txShift_d;
    logic [DATA_WIDTH-2:0]      rxShift_q, rxShift_d;
    logic [DATA_WIDTH-1:0]      dataOut_q, dataOut_d;
    logic                       errFlag_q, errFlag_d;
    logic                       timeout;
    logic                       inXfer;

`ifdef MASTER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] toCnt_q, toCnt_d;
    logic            stalled;

    // A stall is a cycle spent waiting on the slave; any progress or state change restarts the count.
    always_comb begin
        stalled = 1'b0;
        case (state_q)
            S_WAIT_RDY:       stalled = !sready;
            S_RWAIT, S_RDATA: stalled = !svalid;
            default:          stalled = 1'b0;
        endcase
    end

    assign timeout = stalled && (toCnt_q == TO_LAST);

    always_comb begin
        toCnt_d = '0;
        if (stalled && (state_d == state_q)) begin
            toCnt_d = toCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            toCnt_q <= '0;
        end else begin
            toCnt_q <= toCnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        bitCnt_d  = bitCnt_q;
        write_d   = write_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        txShift_d = txShift_q;
        rxShift_d = rxShift_q;
        dataOut_d = dataOut_q;
        errFlag_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (m_execute) begin
                    write_d = m_write;
                    sel_d   = m_slave_sel;
                    addr_d  = m_addr;
                    wdata_d = m_data_in;
                    state_d = S_REQ;
                end
            end

            S_REQ: begin
                if (mgrant) begin
                    txShift_d = MAXW'(sel_q);
                    state_d   = S_SADDR;
                end
            end

            S_SADDR, S_WAIT_RDY, S_ADDR, S_WDATA, S_RWAIT, S_RDATA: begin
                if (!mgrant || timeout) begin
                    errFlag_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    case (state_q)
                        S_SADDR: begin
                            txShift_d = txShift_q >> 1;
                            if (bitCnt_q == SEL_LAST) begin
                                state_d = S_WAIT_RDY;
                            end else begin
                                bitCnt_d = bitCnt_q + 1'b1;
                            end
                        end
                        S_WAIT_RDY: begin
                            if (sready) begin
                                txShift_d = MAXW'(addr_q);
                                state_d   = S_ADDR;
                            end
                        end
                        S_ADDR: begin
                            txShift_d = txShift_q >> 1;
                            if (bitCnt_q == ADDR_LAST) begin
                                if (write_q) begin
                                    txShift_d = MAXW'(wdata_q);
                                    state_d   = S_WDATA;
                                end else begin
                                    state_d = S_RWAIT;
                                end
                            end else begin
                                bitCnt_d = bitCnt_q + 1'b1;
                            end
                        end
                        S_WDATA: begin
                            txShift_d = txShift_q >> 1;
                            if (bitCnt_q == DATA_LAST) begin
                                state_d = S_DONE;
                            end else begin
                                bitCnt_d = bitCnt_q + 1'b1;
                            end
                        end
                        S_RWAIT: begin
                            if (svalid) begin
                                rxShift_d = {sin, rxShift_q[DATA_WIDTH-2:1]};
                                state_d   = S_RDATA;
                            end
                        end
                        S_RDATA: begin
                            if (svalid) begin
                                if (bitCnt_q == DATA_LAST) begin
                                    dataOut_d = {sin, rxShift_q};
                                    state_d   = S_DONE;
                                end else begin
                                    rxShift_d = {sin, rxShift_q[DATA_WIDTH-2:1]};
                                    bitCnt_d  = bitCnt_q + 1'b1;
                                end
                            end
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end

            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // RDATA starts at one because RWAIT already captured bit 0.
        if (state_d != state_q) begin
            bitCnt_d = (state_d == S_RDATA) ? CNT_W'(1) : '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            bitCnt_q  <= '0;
            write_q   <= 1'b0;
            sel_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            txShift_q <= '0;
            rxShift_q <= '0;
            dataOut_q <= '0;
            errFlag_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitCnt_q  <= bitCnt_d;
            write_q   <= write_d;
            sel_q     <= sel_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            txShift_q <= txShift_d;
            rxShift_q <= rxShift_d;
            dataOut_q <= dataOut_d;
            errFlag_q <= errFlag_d;
        end
    end

    assign inXfer     = (state_q == S_SADDR) || (state_q == S_WAIT_RDY) || (state_q == S_ADDR) ||
                        (state_q == S_WDATA) || (state_q == S_RWAIT)    || (state_q == S_RDATA);
    assign m_busy     = (state_q != S_IDLE);
    assign mreq       = (state_q == S_REQ) || inXfer;
    assign mvalid     = (state_q == S_SADDR) || (state_q == S_ADDR) || (state_q == S_WDATA);
    assign mout       = mvalid && txShift_q[0];
    assign mmode      = inXfer && write_q;
    assign m_tx_done  = (state_q == S_DONE);
    assign m_error    = (state_q == S_DONE) && errFlag_q;
    assign m_data_out = dataOut_q;

endmodule
